// File: rtl/cpa_pkg.sv
// Shared types and helpers for the segmented carry-propagate adder.
// The optional subtract mode is enabled with the CPA_SEG_SUB_EN macro.
package cpa_pkg;

    // Control states of the segment sequencer
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Bits resolved per cycle unless the instance overrides it
    localparam int SEG_LEN_DEFAULT = 17;

    // Generate/propagate pair carried through the prefix network
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Number of combine levels needed to span one segment
    function automatic int prefix_levels(input int seg_len);
        return (seg_len > 1) ? $clog2(seg_len) : 0;
    endfunction

    // Generate/propagate combine cell: merges a higher group with the group just below it
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

endpackage

// File: rtl/cpa_seg_prefix.sv
// Combinational SEG_LEN-bit parallel-prefix (Kogge-Stone) adder for one segment.
// The carry-in is folded into the generate term of bit 0, so the group
// generate at bit i is exactly the carry out of bit i.
module cpa_seg_prefix
    import cpa_pkg::*;
#(
    parameter int SEG_LEN = SEG_LEN_DEFAULT
) (
    input  logic [SEG_LEN-1:0] a,
    input  logic [SEG_LEN-1:0] b,
    input  logic               c_in,
    output logic [SEG_LEN-1:0] sum,
    output logic               c_out
);

    localparam int LEVELS = prefix_levels(SEG_LEN);

    logic [SEG_LEN-1:0] p;
    logic [SEG_LEN-1:0] g;
    logic [SEG_LEN-1:0] cur_g;
    logic [SEG_LEN-1:0] cur_p;
    logic [SEG_LEN-1:0] prv_g;
    logic [SEG_LEN-1:0] prv_p;
    logic [SEG_LEN-1:0] grp_g;

    assign p = a ^ b;
    assign g = a & b;

    // Prefix network: each level doubles the span of every group, LEVELS levels deep
    always_comb begin
        cur_g    = g;
        cur_p    = p;
        cur_g[0] = g[0] | (p[0] & c_in);
        prv_g    = cur_g;
        prv_p    = cur_p;
        for (int lvl = 0; lvl < LEVELS; lvl++) begin
            prv_g = cur_g;
            prv_p = cur_p;
            for (int i = (1 << lvl); i < SEG_LEN; i++) begin
                {cur_g[i], cur_p[i]} = gp_combine('{g: prv_g[i], p: prv_p[i]},
                                                  '{g: prv_g[i - (1 << lvl)], p: prv_p[i - (1 << lvl)]});
            end
        end
        grp_g = cur_g;
    end

    // Sum bit i takes the carry out of bit i-1; bit 0 takes the segment carry-in
    always_comb begin
        sum   = p ^ {grp_g[SEG_LEN-2:0], c_in};
        c_out = grp_g[SEG_LEN-1];
    end

endmodule

// File: rtl/cpa_seg_adder.sv
// Multi-cycle carry-propagate adder: one SEG_LEN-bit segment per cycle, LSB first,
// with the inter-segment carry held in a register.
// Define CPA_SEG_SUB_EN to add the sub_in port (A - B with c_out = no borrow).
module cpa_seg_adder
    import cpa_pkg::*;
#(
    parameter int SEG_LEN  = SEG_LEN_DEFAULT,
    parameter int NUM_SEGS = 4,
    parameter int DATA_LEN = SEG_LEN * NUM_SEGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] a_in,
    input  logic [DATA_LEN-1:0] b_in,
    input  logic                c_in,
`ifdef CPA_SEG_SUB_EN
    input  logic                sub_in,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] sum_out,
    output logic                c_out
);

    localparam int IDX_W = (NUM_SEGS > 1) ? $clog2(NUM_SEGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEGS - 1);

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    seg_idx;
    logic                carry_q;
    logic [DATA_LEN-1:0] a_q;
    logic [DATA_LEN-1:0] b_q;
    logic [DATA_LEN-1:0] res_q;
    logic [DATA_LEN-1:0] res_d;
    logic [DATA_LEN-1:0] sum_q;
    logic                cout_q;
    logic [SEG_LEN-1:0]  seg_a;
    logic [SEG_LEN-1:0]  seg_b;
    logic [SEG_LEN-1:0]  seg_sum;
    logic                seg_cout;
    logic [DATA_LEN-1:0] b_cap;
    logic                cin_cap;
    logic                accept;
    logic                last_seg;
    int                  seg_base;

    assign in_ready  = rst_n & (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_valid & in_ready;
    assign last_seg  = (seg_idx == LAST_IDX);
    assign sum_out   = sum_q;
    assign c_out     = cout_q;

`ifdef CPA_SEG_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced high
    always_comb begin
        b_cap   = sub_in ? ~b_in : b_in;
        cin_cap = sub_in | c_in;
    end
`else
    // Pure addition: operands and carry are captured as presented
    always_comb begin
        b_cap   = b_in;
        cin_cap = c_in;
    end
`endif

    // Segment mux: select the operand slice addressed by seg_idx
    always_comb begin
        seg_base = int'(seg_idx) * SEG_LEN;
        seg_a    = a_q[seg_base +: SEG_LEN];
        seg_b    = b_q[seg_base +: SEG_LEN];
    end

    // Merge the freshly resolved segment into the running result
    always_comb begin
        res_d = res_q;
        res_d[seg_base +: SEG_LEN] = seg_sum;
    end

    cpa_seg_prefix #(
        .SEG_LEN (SEG_LEN)
    ) u_prefix (
        .a     (seg_a),
        .b     (seg_b),
        .c_in  (carry_q),
        .sum   (seg_sum),
        .c_out (seg_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept -> run NUM_SEGS cycles -> hold result until taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_seg)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Datapath: capture operands, step through segments, publish the result only when complete
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            seg_idx <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_in;
                        b_q     <= b_cap;
                        carry_q <= cin_cap;
                        seg_idx <= '0;
                    end
                end
                RUN: begin
                    res_q   <= res_d;
                    carry_q <= seg_cout;
                    if (last_seg) begin
                        sum_q   <= res_d;
                        cout_q  <= seg_cout;
                        seg_idx <= '0;
                    end else begin
                        seg_idx <= seg_idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpa_seg_adder.sv
// Scoreboard bench for cpa_seg_adder with directed vectors.
// Define CPA_SEG_SUB_EN to also exercise the subtract mode.
module tb_cpa_seg_adder;

    localparam int DATA_LEN = 68;
    localparam logic [DATA_LEN-1:0] ALL1 = {DATA_LEN{1'b1}};

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] a_in;
    logic [DATA_LEN-1:0] b_in;
    logic                c_in;
    logic                sub_in;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] sum_out;
    logic                c_out;

    typedef struct packed {
        logic [DATA_LEN-1:0] sum;
        logic                cout;
    } result_t;

    typedef struct {
        logic [DATA_LEN-1:0] a;
        logic [DATA_LEN-1:0] b;
        logic                cin;
        logic [DATA_LEN-1:0] s;
        logic                co;
    } vec_t;

    result_t expq[$];
    result_t mon_exp;
    vec_t    vecs[$];
    int      nvec = 0;
    int      nerr = 0;

    cpa_seg_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
`ifdef CPA_SEG_SUB_EN
        .sub_in    (sub_in),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_out   (sum_out),
        .c_out     (c_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_LEN-1:0] actual,
                               input logic [DATA_LEN-1:0] required);
        nvec++;
        if (actual !== required) begin
            nerr++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_LEN-1:0] a, input logic [DATA_LEN-1:0] b,
                                 input logic cin, input logic sub, input bit push,
                                 input logic [DATA_LEN-1:0] exp_sum, input logic exp_cout);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("in_ready_wait", DATA_LEN'(in_ready), DATA_LEN'(1));
        a_in     = a;
        b_in     = b;
        c_in     = cin;
        sub_in   = sub;
        in_valid = 1'b1;
        if (push) expq.push_back('{sum: exp_sum, cout: exp_cout});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = 'x;
        b_in     = 'x;
        c_in     = 1'b0;
        sub_in   = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Monitor: whenever a result is handed over, compare against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                nvec++;
                nerr++;
                $display("[TB] FAIL unexpected_result: got sum 0x%0h, expected no result", sum_out);
            end else begin
                mon_exp = expq.pop_front();
                checkOutput("sum_out", sum_out, mon_exp.sum);
                checkOutput("c_out", DATA_LEN'(c_out), DATA_LEN'(mon_exp.cout));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        bit  seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        c_in      = 1'b0;
        sub_in    = 1'b0;

        vecs.push_back('{a: ALL1, b: 68'd1, cin: 1'b0, s: 68'd0, co: 1'b1});
        vecs.push_back('{a: 68'h1FFFF, b: 68'h1, cin: 1'b0, s: 68'h20000, co: 1'b0});
        vecs.push_back('{a: 68'd0, b: 68'd0, cin: 1'b1, s: 68'd1, co: 1'b0});
        vecs.push_back('{a: 68'h12345, b: 68'hABCDE, cin: 1'b0, s: 68'hBE023, co: 1'b0});
        vecs.push_back('{a: ALL1, b: ALL1, cin: 1'b1, s: ALL1, co: 1'b1});
        vecs.push_back('{a: 68'h8_0000_0000_0000_0000, b: 68'h8_0000_0000_0000_0000, cin: 1'b0, s: 68'd0, co: 1'b1});
        vecs.push_back('{a: 68'hF_FFFF_FFFF, b: 68'd1, cin: 1'b0, s: 68'h10_0000_0000, co: 1'b0});

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", DATA_LEN'(out_valid), '0);
        checkOutput("reset_sum_out", sum_out, '0);
        checkOutput("reset_c_out", DATA_LEN'(c_out), '0);
        checkOutput("reset_in_ready", DATA_LEN'(in_ready), '0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_in_ready", DATA_LEN'(in_ready), DATA_LEN'(1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, 1'b1, vecs[i].s, vecs[i].co);
            waitResult(lat);
            checkOutput("latency", DATA_LEN'(lat), DATA_LEN'(4));
            @(posedge clk);
            #1;
            checkOutput("out_valid_drop", DATA_LEN'(out_valid), '0);
        end

        out_ready = 1'b0;
        applyStimulus(68'd100, 68'd23, 1'b0, 1'b0, 1'b1, 68'd123, 1'b0);
        waitResult(lat);
        checkOutput("bp_latency", DATA_LEN'(lat), DATA_LEN'(4));
        in_valid = 1'b1;
        a_in     = 68'd5;
        b_in     = 68'd5;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_sum_hold", sum_out, 68'd123);
            checkOutput("bp_cout_hold", DATA_LEN'(c_out), '0);
            checkOutput("bp_in_ready", DATA_LEN'(in_ready), '0);
            checkOutput("bp_out_valid", DATA_LEN'(out_valid), DATA_LEN'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_out_valid", DATA_LEN'(out_valid), '0);
        checkOutput("bp_release_in_ready", DATA_LEN'(in_ready), DATA_LEN'(1));

        applyStimulus(68'd9, 68'd9, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("mid_reset_in_ready", DATA_LEN'(in_ready), DATA_LEN'(1));
        seen = out_valid;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        checkOutput("mid_reset_no_valid", DATA_LEN'(seen), '0);
        applyStimulus(68'd3, 68'd4, 1'b0, 1'b0, 1'b1, 68'd7, 1'b0);
        waitResult(lat);
        checkOutput("after_reset_latency", DATA_LEN'(lat), DATA_LEN'(4));
        @(posedge clk);
        #1;

`ifdef CPA_SEG_SUB_EN
        applyStimulus(68'd5, 68'd7, 1'b0, 1'b1, 1'b1, ALL1 - 68'd1, 1'b0);
        waitResult(lat);
        @(posedge clk);
        #1;
        applyStimulus(68'd7, 68'd5, 1'b0, 1'b1, 1'b1, 68'd2, 1'b1);
        waitResult(lat);
        @(posedge clk);
        #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", DATA_LEN'(expq.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
